// File: rtl/bitty_fetch.sv
// bitty_fetch: instruction queue between a host writer and bitty_core.
// A circular buffer of DEPTH 16-bit words. The head word is presented
// combinationally on `instruction`; a core_done pulse retires it.
// Optional feature macro: BITTY_FETCH_RETIRE_CNT_EN adds an 8-bit
// wrapping retire counter output (retired_cnt).
module bitty_fetch #(
    parameter int          DEPTH      = 8,
    parameter logic [15:0] IDLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        flush,
    input  logic        core_done,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [4:0]  level
`ifdef BITTY_FETCH_RETIRE_CNT_EN
    ,
    output logic [7:0]  retired_cnt
`endif
);

    localparam int         PTR_W      = $clog2(DEPTH);
    localparam logic [4:0] FULL_LEVEL = 5'(DEPTH);

    // Storage is deliberately not reset; level gating keeps stale words hidden.
    logic [15:0]      mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [4:0]       level_reg;

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;

    assign not_empty = (level_reg != 5'd0);
    assign not_full  = (level_reg != FULL_LEVEL);

    // Flush blocks both sides so a concurrent write or retire is discarded.
    assign wr_ready = not_full && !flush;
    assign push     = wr_valid && wr_ready;
    // An empty queue cannot retire, so a word pushed into an empty queue
    // is only visible (and poppable) from the following cycle.
    assign pop      = core_done && not_empty && !flush;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= 5'd0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_reg + {4'd0, push} - {4'd0, pop};
        end
    end

    // Word storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign instruction = not_empty ? mem[rd_ptr_reg] : IDLE_INSTR;
    assign instr_valid = not_empty;
    assign level       = level_reg;

`ifdef BITTY_FETCH_RETIRE_CNT_EN
    logic [7:0] retired_cnt_reg;

    // Count real retirements only; ignored core_done pulses never reach pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt_reg <= 8'd0;
        end else if (flush) begin
            retired_cnt_reg <= 8'd0;
        end else if (pop) begin
            retired_cnt_reg <= retired_cnt_reg + 8'd1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
`endif

endmodule
